shift_pipe: RTL and testbench

SHIFT_PIPE -- requirements
Module: shift_pipe

---
 rtl/shift_pipe.sv | 127 ++++++++++++
 tb/tb_shift_pipe.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_pipe.sv
// Pipelined barrel shifter with a valid/ready handshake.
// The log2(XLEN) mux levels are spread over PIPE register stages.
module shift_pipe #(
    parameter int XLEN = 32,
    parameter int PIPE = 2,
    parameter int TAGW = 5
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [2:0]      i_op,
    input  logic [XLEN-1:0] i_a,
    input  logic [XLEN-1:0] i_b,
    input  logic [TAGW-1:0] i_tag,
    output logic            o_valid,
    input  logic            i_ready,
    output logic [XLEN-1:0] o_result,
    output logic [TAGW-1:0] o_tag
);

    localparam int SHW   = $clog2(XLEN);
    localparam int BASE  = SHW / PIPE;
    localparam int EXTRA = SHW % PIPE;

    localparam logic [2:0] OP_SLL = 3'b000;
    localparam logic [2:0] OP_SRL = 3'b001;
    localparam logic [2:0] OP_SRA = 3'b010;
    localparam logic [2:0] OP_ROL = 3'b011;
    localparam logic [2:0] OP_ROR = 3'b100;

    typedef struct packed {
        logic            v;
        logic [2:0]      op;
        logic [SHW-1:0]  sh;
        logic [XLEN-1:0] data;
        logic [TAGW-1:0] tag;
    } beat_t;

    // Earlier stages take the leftover levels when SHW does not divide evenly.
    function automatic int level_stage(input int lvl);
        int lo;
        int n;
        int st;
        lo = 0;
        st = 0;
        for (int s = 0; s < PIPE; s++) begin
            n = BASE + ((s < EXTRA) ? 1 : 0);
            if (lvl >= lo && lvl < lo + n) st = s;
            lo = lo + n;
        end
        return st;
    endfunction

    function automatic logic [XLEN-1:0] shift_level(
        input logic [XLEN-1:0] d,
        input logic [2:0]      op,
        input int              amt
    );
        logic [XLEN-1:0] fill;
        logic [XLEN-1:0] r;
        fill = {XLEN{d[XLEN-1]}};
        case (op)
            OP_SLL:  r = d << amt;
            OP_SRL:  r = d >> amt;
            OP_SRA:  r = (d >> amt) | (fill & ~({XLEN{1'b1}} >> amt));
            OP_ROL:  r = (d << amt) | (d >> (XLEN - amt));
            OP_ROR:  r = (d >> amt) | (d << (XLEN - amt));
            default: r = d;
        endcase
        return r;
    endfunction

    beat_t q   [PIPE];
    beat_t nxt [PIPE];
    beat_t in_beat;
    logic  stall;
    logic  unused_b;

    assign unused_b = ^i_b[XLEN-1:SHW];

    assign in_beat = '{
        v:    i_valid,
        op:   i_op,
        sh:   i_b[SHW-1:0],
        data: i_a,
        tag:  i_tag
    };

    assign o_valid  = q[PIPE-1].v;
    assign o_result = q[PIPE-1].data;
    assign o_tag    = q[PIPE-1].tag;
    assign stall    = o_valid && !i_ready;
    assign o_ready  = !stall;

    always_comb begin
        nxt[0] = in_beat;
        for (int s = 1; s < PIPE; s++) begin
            nxt[s] = q[s-1];
        end
        for (int s = 0; s < PIPE; s++) begin
            for (int j = 0; j < SHW; j++) begin
                if (level_stage(j) == s && nxt[s].sh[j]) begin
                    nxt[s].data = shift_level(nxt[s].data, nxt[s].op, 1 << j);
                end
            end
        end
    end

    // Payload only loads with a valid beat so outputs keep the last result.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int s = 0; s < PIPE; s++) begin
                q[s] <= '0;
            end
        end else if (!stall) begin
            for (int s = 0; s < PIPE; s++) begin
                if (nxt[s].v) begin
                    q[s] <= nxt[s];
                end else begin
                    q[s].v <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_shift_pipe.sv
// Self-checking bench for shift_pipe: directed cases on a 32/2 instance
// plus randomized traffic on a parameter sweep against a queue model.
module tb_shift_pipe;

    localparam int SWEEP_CYC = 1500;

    typedef struct {
        logic [63:0] r;
        logic [4:0]  t;
        int          pos;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [63:0] got,
                       input logic [63:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    function automatic logic [63:0] ref_shift(input int xl, input logic [2:0] op,
                                              input logic [63:0] a,
                                              input logic [63:0] b);
        int sh;
        logic [63:0] r;
        r  = '0;
        sh = int'(b[5:0]) % xl;
        for (int i = 0; i < xl; i++) begin
            case (op)
                3'd0:    r[i] = (i >= sh) ? a[i-sh] : 1'b0;
                3'd1:    r[i] = (i + sh < xl) ? a[i+sh] : 1'b0;
                3'd2:    r[i] = (i + sh < xl) ? a[i+sh] : a[xl-1];
                3'd3:    r[i] = a[(i - sh + xl) % xl];
                3'd4:    r[i] = a[(i + sh) % xl];
                default: r[i] = a[i];
            endcase
        end
        return r;
    endfunction

    function automatic int cfg_xl(input int k);
        case (k)
            0, 1:    return 8;
            2, 3, 6: return 32;
            default: return 64;
        endcase
    endfunction

    function automatic int cfg_pp(input int k);
        case (k)
            1:       return 3;
            3:       return 5;
            5:       return 6;
            6:       return 2;
            default: return 1;
        endcase
    endfunction

    // ---------------- directed instance ----------------
    logic        d_rst, d_valid, d_ready_o, d_ovalid, d_iready;
    logic [2:0]  d_op;
    logic [31:0] d_a, d_b, d_res;
    logic [4:0]  d_tag, d_otag;

    shift_pipe #(.XLEN(32), .PIPE(2), .TAGW(5)) dut (
        .i_clk(clk), .i_rst(d_rst), .i_valid(d_valid), .o_ready(d_ready_o),
        .i_op(d_op), .i_a(d_a), .i_b(d_b), .i_tag(d_tag),
        .o_valid(d_ovalid), .i_ready(d_iready),
        .o_result(d_res), .o_tag(d_otag)
    );

    logic [31:0] got_r[$];
    logic [4:0]  got_t[$];
    int          got_c[$];

    always @(negedge clk) begin
        if (!d_rst && d_ovalid && d_iready) begin
            got_r.push_back(d_res);
            got_t.push_back(d_otag);
            got_c.push_back(cyc);
        end
    end

    function automatic logic [63:0] gr(input int i);
        return (i < got_r.size()) ? 64'(got_r[i]) : 'x;
    endfunction

    function automatic logic [63:0] gt(input int i);
        return (i < got_t.size()) ? 64'(got_t[i]) : 'x;
    endfunction

    function automatic logic [63:0] gc(input int i);
        return (i < got_c.size()) ? 64'(got_c[i]) : 'x;
    endfunction

    task automatic clear_got();
        got_r.delete();
        got_t.delete();
        got_c.delete();
    endtask

    task automatic send(input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] tag);
        d_valid = 1'b1;
        d_op    = op;
        d_a     = a;
        d_b     = b;
        d_tag   = tag;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        d_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        d_rst = 1'b1; d_valid = 1'b1; d_op = 3'd0;
        d_a = 32'd1; d_b = 32'd1; d_tag = 5'd7; d_iready = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_ovalid", 64'(d_ovalid), 64'd0);
        chk("rst_result", 64'(d_res), 64'd0);
        chk("rst_tag", 64'(d_otag), 64'd0);
        d_rst = 1'b0; d_valid = 1'b0;
        #1;
        chk("ready_after_rst", 64'(d_ready_o), 64'd1);
        @(posedge clk);
        #1;
        chk("no_accept_in_rst", 64'(d_ovalid), 64'd0);

        send(3'd2, 32'h8000_0000, 32'd4, 5'd3);
        d_valid = 1'b0;
        chk("sra_not_early", 64'(d_ovalid), 64'd0);
        @(posedge clk);
        #1;
        chk("sra_ovalid", 64'(d_ovalid), 64'd1);
        chk("sra_result", 64'(d_res), 64'hF800_0000);
        chk("sra_tag", 64'(d_otag), 64'd3);
        chk("model_sra", ref_shift(32, 3'd2, 64'h8000_0000, 64'd4), 64'hF800_0000);
        idle(2);

        clear_got();
        send(3'd0, 32'h1, 32'd31, 5'd1);
        send(3'd1, 32'h8000_0000, 32'd31, 5'd2);
        send(3'd4, 32'h1, 32'd1, 5'd3);
        idle(4);
        chk("b2b_count", 64'(got_r.size()), 64'd3);
        chk("b2b_r0", gr(0), 64'h8000_0000);
        chk("b2b_r1", gr(1), 64'h1);
        chk("b2b_r2", gr(2), 64'h8000_0000);
        chk("b2b_t2", gt(2), 64'd3);
        chk("b2b_consecutive", gc(2) - gc(0), 64'd2);
        chk("model_sll", ref_shift(32, 3'd0, 64'h1, 64'd31), 64'h8000_0000);
        chk("model_ror", ref_shift(32, 3'd4, 64'h1, 64'd1), 64'h8000_0000);

        clear_got();
        send(3'd3, 32'h1234_5678, 32'h24, 5'd9);
        idle(3);
        chk("rol_mask", gr(0), 64'h2345_6781);
        chk("model_rol", ref_shift(32, 3'd3, 64'h1234_5678, 64'h24), 64'h2345_6781);

        clear_got();
        d_iready = 1'b0;
        send(3'd0, 32'h3, 32'd1, 5'd10);
        send(3'd1, 32'hF0, 32'd4, 5'd11);
        d_valid = 1'b1; d_op = 3'd4; d_a = 32'h2; d_b = 32'd1; d_tag = 5'd12;
        for (int i = 0; i < 5; i++) begin
            chk("bp_oready", 64'(d_ready_o), 64'd0);
            chk("bp_ovalid", 64'(d_ovalid), 64'd1);
            chk("bp_hold_res", 64'(d_res), 64'h6);
            chk("bp_hold_tag", 64'(d_otag), 64'd10);
            @(posedge clk);
            #1;
        end
        d_iready = 1'b1;
        @(posedge clk);
        #1;
        idle(4);
        chk("bp_count", 64'(got_r.size()), 64'd3);
        chk("bp_r0", gr(0), 64'h6);
        chk("bp_r1", gr(1), 64'hF);
        chk("bp_r2", gr(2), 64'h1);
        chk("bp_t1", gt(1), 64'd11);
        chk("bp_t2", gt(2), 64'd12);

        clear_got();
        send(3'd0, 32'h5, 32'd1, 5'd1);
        send(3'd0, 32'h6, 32'd1, 5'd2);
        d_valid = 1'b0;
        d_rst = 1'b1;
        @(posedge clk);
        #1;
        d_rst = 1'b0;
        chk("midrst_ovalid", 64'(d_ovalid), 64'd0);
        idle(6);
        chk("midrst_no_stale", 64'(got_r.size()), 64'd0);

        while (cyc < SWEEP_CYC + 60) begin
            @(posedge clk);
        end
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // ---------------- randomized parameter sweep ----------------
    for (genvar k = 0; k < 7; k++) begin : g_sweep
        localparam int XL = cfg_xl(k);
        localparam int PP = cfg_pp(k);

        logic          rst, v, rdy_o, ov, rdy_i;
        logic [2:0]    op;
        logic [XL-1:0] a, b, res;
        logic [4:0]    tag, otag;
        exp_t          q[$];
        bit            armed = 1'b0;

        shift_pipe #(.XLEN(XL), .PIPE(PP), .TAGW(5)) u_dut (
            .i_clk(clk), .i_rst(rst), .i_valid(v), .o_ready(rdy_o),
            .i_op(op), .i_a(a), .i_b(b), .i_tag(tag),
            .o_valid(ov), .i_ready(rdy_i),
            .o_result(res), .o_tag(otag)
        );

        initial begin
            logic [63:0] bv;
            rst = 1'b1; v = 1'b0; rdy_i = 1'b1;
            op = 3'd0; a = '0; b = '0; tag = '0;
            repeat (2) @(posedge clk);
            for (int c = 0; c < SWEEP_CYC; c++) begin
                #1;
                rst   = ($urandom_range(0, 199) == 0);
                v     = ($urandom_range(0, 3) != 0);
                rdy_i = ($urandom_range(0, 3) != 0);
                op    = 3'($urandom_range(0, 7));
                a     = XL'({$urandom, $urandom});
                bv    = {$urandom, $urandom};
                if ($urandom_range(0, 5) == 0) bv[5:0] = 6'd0;
                b     = XL'(bv);
                tag   = 5'($urandom);
                @(posedge clk);
            end
            #1;
            rst = 1'b0; v = 1'b0; rdy_i = 1'b1;
        end

        initial forever begin
            bit exp_ov;
            bit stall;
            string nm;
            @(posedge clk);
            #2;
            nm = $sformatf("x%0d_p%0d", XL, PP);
            exp_ov = (q.size() > 0) && (q[0].pos == PP - 1);
            if (armed) begin
                chk({nm, "_ovalid"}, 64'(ov), 64'(exp_ov));
                if (exp_ov && ov === 1'b1) begin
                    chk({nm, "_result"}, 64'(res), q[0].r);
                    chk({nm, "_tag"}, 64'(otag), 64'(q[0].t));
                end
                chk({nm, "_oready"}, 64'(rdy_o), 64'(!(exp_ov && !rdy_i)));
            end
            stall = exp_ov && !rdy_i;
            if (rst) begin
                q.delete();
                armed = 1'b1;
            end else if (!stall) begin
                if (exp_ov) void'(q.pop_front());
                foreach (q[i]) q[i].pos++;
                if (v) q.push_back('{ref_shift(XL, op, 64'(a), 64'(b)), tag, 0});
            end
        end
    end

endmodule
